// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with threshold flags, error pulses,
// sticky error flags and selectable standard / first-word-fall-through read.
module param_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_enable,
  input  logic                     read_enable,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     overrun,
  output logic                     underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             ovr_q, ovr_d;
  logic             udr_q, udr_d;

  logic             wr_ok;
  logic             rd_ok;
  logic [CW-1:0]    remain;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));

  assign rd_ok = read_enable && !empty;
  assign wr_ok = write_enable && (!full || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Entries left after this cycle's read, before this cycle's write lands
  assign remain = count_q - {{AW{1'b0}}, rd_ok};

  always_comb begin
    dout_d = dout_q;
    if (FWFT != 0) begin
      if (count_d == '0) begin
        dout_d = dout_q;
      end else if (remain == '0) begin
        dout_d = data_in;
      end else begin
        dout_d = mem_q[rd_ptr_d];
      end
    end else if (rd_ok) begin
      dout_d = mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    ovf_d = write_enable && full && !rd_ok;
    udf_d = read_enable && empty;
    ovr_d = ovf_d || (ovr_q && !clear_err);
    udr_d = udf_d || (udr_q && !clear_err);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      ovr_q    <= 1'b0;
      udr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      ovr_q    <= ovr_d;
      udr_q    <= udr_d;
    end
  end

  assign data_out  = dout_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign overrun   = ovr_q;
  assign underrun  = udr_q;

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: standard-mode instance with a
// reference model plus a directed first-word-fall-through instance.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       we, re, clr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full, empty, af, ae;
  logic [4:0] cnt;
  logic       ovf, udf, ovr, udr;

  logic       we2, re2, clr2;
  logic [7:0] din2;
  logic [7:0] dout2;
  logic       full2, empty2, af2, ae2;
  logic [4:0] cnt2;
  logic       ovf2, udf2, ovr2, udr2;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb[$];
  int         mcount;
  logic [7:0] mdout;
  logic       movr, mudr;

  always #5 clk = ~clk;

  param_fifo dut (
    .clk(clk), .rst(rst),
    .write_enable(we), .read_enable(re),
    .data_in(din), .clear_err(clr),
    .data_out(dout), .full(full), .empty(empty),
    .almost_full(af), .almost_empty(ae),
    .count(cnt), .overflow(ovf), .underflow(udf),
    .overrun(ovr), .underrun(udr)
  );

  param_fifo #(.FWFT(1)) dut2 (
    .clk(clk), .rst(rst),
    .write_enable(we2), .read_enable(re2),
    .data_in(din2), .clear_err(clr2),
    .data_out(dout2), .full(full2), .empty(empty2),
    .almost_full(af2), .almost_empty(ae2),
    .count(cnt2), .overflow(ovf2), .underflow(udf2),
    .overrun(ovr2), .underrun(udr2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, 32'(cnt), 32'(mcount));
    chk({tag, ".full"}, 32'(full), 32'(mcount == 16));
    chk({tag, ".empty"}, 32'(empty), 32'(mcount == 0));
    chk({tag, ".af"}, 32'(af), 32'(mcount >= 14));
    chk({tag, ".ae"}, 32'(ae), 32'(mcount <= 2));
    chk({tag, ".dout"}, 32'(dout), 32'(mdout));
    chk({tag, ".ovr"}, 32'(ovr), 32'(movr));
    chk({tag, ".udr"}, 32'(udr), 32'(mudr));
  endtask

  task automatic step(input logic w, input logic r,
                      input logic [7:0] d, input logic c,
                      input string tag);
    logic wa, ra, eo, eu;
    ra = r && (mcount > 0);
    wa = w && ((mcount < 16) || ra);
    eo = w && (mcount == 16) && !ra;
    eu = r && (mcount == 0);
    we = w; re = r; din = d; clr = c;
    if (ra) mdout = sb.pop_front();
    if (wa) sb.push_back(d);
    mcount = mcount + (wa ? 1 : 0) - (ra ? 1 : 0);
    movr = eo || (movr && !c);
    mudr = eu || (mudr && !c);
    @(posedge clk); #1;
    we = 0; re = 0; clr = 0;
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    chk({tag, ".udf"}, 32'(udf), 32'(eu));
    chk_model(tag);
  endtask

  task automatic step2(input logic w, input logic r,
                       input logic [7:0] d);
    we2 = w; re2 = r; din2 = d;
    @(posedge clk); #1;
    we2 = 0; re2 = 0;
  endtask

  task automatic model_reset();
    sb.delete();
    mcount = 0; mdout = 0; movr = 0; mudr = 0;
  endtask

  initial begin
    rst = 0;
    we = 0; re = 0; clr = 0; din = 0;
    we2 = 0; re2 = 0; clr2 = 0; din2 = 0;
    model_reset();
    #12;
    chk_model("reset");
    chk("reset.ovf", 32'(ovf), 0);
    chk("reset.udf", 32'(udf), 0);
    @(posedge clk); #1;
    rst = 1;

    for (int i = 1; i <= 16; i++)
      step(1, 0, 8'(i), 0, "fill");

    step(1, 0, 8'hAA, 0, "ovf");
    step(0, 0, 8'h00, 0, "ovf_idle");

    for (int i = 0; i < 16; i++)
      step(0, 1, 8'h00, 0, "drain");

    step(0, 0, 8'h00, 1, "clr1");

    step(1, 1, 8'h55, 0, "udf");
    step(0, 1, 8'h00, 0, "rd55");
    step(0, 0, 8'h00, 1, "clr2");

    for (int i = 0; i < 16; i++)
      step(1, 0, 8'(8'hC0 + i), 0, "fill2");
    for (int i = 0; i < 20; i++)
      step(1, 1, 8'h77, 0, "rdwr_full");
    for (int i = 0; i < 16; i++)
      step(0, 1, 8'h00, 0, "drain2");

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), 1'($urandom_range(0, 15) == 0), "rand");

    while (mcount > 0)
      step(0, 1, 8'h00, 0, "drain3");
    step(0, 0, 8'h00, 1, "clr3");

    for (int i = 0; i < 9; i++)
      step(1, 0, 8'(8'h90 + i), 0, "fill9");
    step(0, 1, 8'h00, 0, "rd9");
    #3;
    rst = 0;
    model_reset();
    #1;
    chk_model("async_rst");
    chk("async_rst.ovf", 32'(ovf), 0);
    chk("async_rst.udf", 32'(udf), 0);
    @(posedge clk); #3;
    rst = 1;
    #1;
    step(0, 1, 8'h00, 0, "post_rst");

    step2(1, 0, 8'h3C);
    chk("fwft.empty0", 32'(empty2), 0);
    chk("fwft.head3c", 32'(dout2), 32'h3C);
    step2(0, 0, 8'h00);
    chk("fwft.hold", 32'(dout2), 32'h3C);
    step2(0, 1, 8'h00);
    chk("fwft.empty1", 32'(empty2), 1);
    chk("fwft.keep3c", 32'(dout2), 32'h3C);
    step2(1, 0, 8'h11);
    step2(1, 0, 8'h22);
    chk("fwft.head11", 32'(dout2), 32'h11);
    chk("fwft.cnt2", 32'(cnt2), 2);
    step2(1, 1, 8'h33);
    chk("fwft.head22", 32'(dout2), 32'h22);
    step2(0, 1, 8'h00);
    chk("fwft.head33", 32'(dout2), 32'h33);
    step2(0, 1, 8'h00);
    chk("fwft.empty2", 32'(empty2), 1);
    chk("fwft.keep33", 32'(dout2), 32'h33);
    step2(0, 1, 8'h00);
    chk("fwft.udf", 32'(udf2), 1);
    chk("fwft.udr", 32'(udr2), 1);
    chk("fwft.keep33b", 32'(dout2), 32'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
